fight_referee: RTL and testbench

- Downstream of the two player blocks. Consumes both players' 2-bit health outputs and decides KO, timeout, round and match outcomes.
- Runs the round timer and drives the shared active-low reset of both player blocks between rounds.
- Best-of-N match controller for the fighting game; results feed the display/scoreboard logic.

---
 rtl/fight_referee.sv | 150 +++++++++++++++
 tb/tb_fight_referee.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fight_referee.sv
// fight_referee: best-of-N round/match referee; runs the round timer and holds the players in reset between rounds
module fight_referee #(
  parameter int ROUND_TICKS = 99,
  parameter int END_HOLD = 4,
  parameter int WINS_TO_MATCH = 2,
  parameter int GUARD = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       game_tick,
  input  logic [1:0] left_health,
  input  logic [1:0] right_health,
  output logic       player_rst_n,
  output logic       fight_active,
  output logic [7:0] round_timer,
  output logic [2:0] round_num,
  output logic [1:0] left_wins,
  output logic [1:0] right_wins,
  output logic [1:0] round_result,
  output logic       match_over,
  output logic [1:0] match_winner
);
  localparam logic [7:0] TICKS = 8'(ROUND_TICKS);
  localparam logic [7:0] HOLD = 8'(END_HOLD);
  localparam logic [7:0] GRD = 8'(GUARD);
  localparam logic [1:0] WINS = 2'(WINS_TO_MATCH);
  typedef enum logic [1:0] {S_IDLE, S_FIGHT, S_END, S_OVER} state_t;
  state_t r_state, w_state;
  logic       r_rst_n, w_rst_n, r_active, w_active, r_over, w_over;
  logic [7:0] r_timer, w_timer, r_guard, w_guard, r_hold, w_hold;
  logic [2:0] r_num, w_num;
  logic [1:0] r_lw, w_lw, r_rw, w_rw, r_result, w_result, r_winner, w_winner;
  logic [1:0] r_prev_l, w_prev_l, r_prev_r, w_prev_r, w_res;
  logic       w_ko_l, w_ko_r, w_end, w_enter;
  always_comb begin
    w_state = r_state;
    w_rst_n = r_rst_n;
    w_active = r_active;
    w_over = r_over;
    w_timer = r_timer;
    w_guard = r_guard;
    w_hold = r_hold;
    w_num = r_num;
    w_lw = r_lw;
    w_rw = r_rw;
    w_result = r_result;
    w_winner = r_winner;
    w_prev_l = r_prev_l;
    w_prev_r = r_prev_r;
    w_enter = 1'b0;
    // a 1 -> 3 step can only be the 2-bit health wrapping past zero
    w_ko_l = left_health == 2'd0 || (r_prev_l == 2'd1 && left_health == 2'd3);
    w_ko_r = right_health == 2'd0 || (r_prev_r == 2'd1 && right_health == 2'd3);
    w_res = (w_ko_l || w_ko_r) ? {w_ko_l, w_ko_r} :
            left_health > right_health ? 2'b01 :
            right_health > left_health ? 2'b10 : 2'b11;
    w_end = w_ko_l || w_ko_r || r_timer == 8'd0;
    case (r_state)
      S_IDLE, S_OVER: if (start) begin
        w_enter = 1'b1;
        w_num = 3'd1;
        w_lw = 2'd0;
        w_rw = 2'd0;
        w_over = 1'b0;
        w_winner = 2'b00;
      end
      S_FIGHT: begin
        if (game_tick && r_timer != 8'd0) w_timer = r_timer - 8'd1;
        if (r_guard != 8'd0) w_guard = r_guard - 8'd1;
        else begin
          w_prev_l = left_health;
          w_prev_r = right_health;
          if (w_end) begin
            w_state = S_END;
            w_rst_n = 1'b0;
            w_active = 1'b0;
            w_hold = HOLD;
            w_result = w_res;
            if (w_res == 2'b01 && r_lw < WINS) w_lw = r_lw + 2'd1;
            if (w_res == 2'b10 && r_rw < WINS) w_rw = r_rw + 2'd1;
          end
        end
      end
      default: if (r_hold > 8'd1) w_hold = r_hold - 8'd1;
      else if (r_lw == WINS || r_rw == WINS) begin
        w_hold = 8'd0;
        w_state = S_OVER;
        w_over = 1'b1;
        w_winner = r_lw == WINS ? 2'b01 : 2'b10;
      end else begin
        w_hold = 8'd0;
        w_enter = 1'b1;
        w_num = r_num == 3'd7 ? 3'd7 : r_num + 3'd1;
      end
    endcase
    if (w_enter) begin
      w_state = S_FIGHT;
      w_rst_n = 1'b1;
      w_active = 1'b1;
      w_timer = TICKS;
      w_guard = GRD;
      w_result = 2'b00;
      w_prev_l = 2'd3;
      w_prev_r = 2'd3;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rst_n <= 1'b0;
      r_active <= 1'b0;
      r_over <= 1'b0;
      r_timer <= TICKS;
      r_guard <= 8'd0;
      r_hold <= 8'd0;
      r_num <= 3'd0;
      r_lw <= 2'd0;
      r_rw <= 2'd0;
      r_result <= 2'b00;
      r_winner <= 2'b00;
      r_prev_l <= 2'd3;
      r_prev_r <= 2'd3;
    end else begin
      r_state <= w_state;
      r_rst_n <= w_rst_n;
      r_active <= w_active;
      r_over <= w_over;
      r_timer <= w_timer;
      r_guard <= w_guard;
      r_hold <= w_hold;
      r_num <= w_num;
      r_lw <= w_lw;
      r_rw <= w_rw;
      r_result <= w_result;
      r_winner <= w_winner;
      r_prev_l <= w_prev_l;
      r_prev_r <= w_prev_r;
    end
  end
  assign player_rst_n = r_rst_n;
  assign fight_active = r_active;
  assign round_timer = r_timer;
  assign round_num = r_num;
  assign left_wins = r_lw;
  assign right_wins = r_rw;
  assign round_result = r_result;
  assign match_over = r_over;
  assign match_winner = r_winner;
endmodule

// File: tb/tb_fight_referee.sv
// tb_fight_referee: randomized rounds scored by a round-outcome model, checked by a decoupled monitor
module tb_fight_referee;
  localparam int TICKS = 99, HOLD = 4, WINS = 2, GRD = 2;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, game_tick = 1'b0;
  logic [1:0] left_health = 2'd3, right_health = 2'd3;
  logic player_rst_n, fight_active, match_over;
  logic [7:0] round_timer;
  logic [2:0] round_num;
  logic [1:0] left_wins, right_wins, round_result, match_winner;
  typedef struct {int res; int lw; int rw; int num; int timer;} rec_t;
  rec_t rq[$];
  int sq[$];
  int mq[$];
  int tests = 0, fails = 0;
  int m_lw, m_rw, m_num, ticks;
  logic pf = 1'b0, pm = 1'b0, in_end = 1'b0;
  int hold_cnt = 0;
  fight_referee #(.ROUND_TICKS(TICKS), .END_HOLD(HOLD), .WINS_TO_MATCH(WINS), .GUARD(GRD)) dut (
    .clk(clk), .rst(rst), .start(start), .game_tick(game_tick),
    .left_health(left_health), .right_health(right_health),
    .player_rst_n(player_rst_n), .fight_active(fight_active),
    .round_timer(round_timer), .round_num(round_num),
    .left_wins(left_wins), .right_wins(right_wins),
    .round_result(round_result), .match_over(match_over),
    .match_winner(match_winner)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // monitor: round end, round start and match end events
  always @(negedge clk) begin
    rec_t r;
    if (rst) begin
      pf = 1'b0;
      pm = 1'b0;
      in_end = 1'b0;
    end else begin
      if (pf && !fight_active) begin
        if (rq.size() == 0) chk("unexpected_round_end", 1, 0);
        else begin
          r = rq.pop_front();
          chk("round_result", round_result, r.res);
          chk("left_wins", left_wins, r.lw);
          chk("right_wins", right_wins, r.rw);
          chk("end_round_num", round_num, r.num);
          chk("end_timer", round_timer, r.timer);
          chk("end_player_rst_n", player_rst_n, 0);
        end
        in_end = 1'b1;
        hold_cnt = 0;
      end
      if (in_end && !fight_active && !match_over) hold_cnt++;
      if (!pf && fight_active) begin
        if (in_end) chk("hold_cycles", hold_cnt, HOLD);
        in_end = 1'b0;
        if (sq.size() == 0) chk("unexpected_round_start", 1, 0);
        else chk("start_round_num", round_num, sq.pop_front());
        chk("start_timer", round_timer, TICKS);
        chk("start_result", round_result, 0);
        chk("start_player_rst_n", player_rst_n, 1);
      end
      if (!pm && match_over) begin
        if (in_end) chk("hold_cycles_match", hold_cnt, HOLD);
        in_end = 1'b0;
        if (mq.size() == 0) chk("unexpected_match_over", 1, 0);
        else chk("match_winner", match_winner, mq.pop_front());
        chk("over_player_rst_n", player_rst_n, 0);
        chk("over_fight_active", fight_active, 0);
      end
      pf = fight_active;
      pm = match_over;
    end
  end
  task automatic step(input int l, input int r, input int t, input int s);
    left_health = 2'(l);
    right_health = 2'(r);
    game_tick = (t != 0);
    start = (s != 0);
    @(negedge clk);
  endtask
  function automatic int safe(input int p);
    int v = $urandom_range(1, 3);
    if (p == 1 && v == 3) v = 2;
    return v;
  endfunction
  function automatic int gnoise();
    return ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3);
  endfunction
  task automatic check_reset(input string tag);
    chk({tag, "_player_rst_n"}, player_rst_n, 0);
    chk({tag, "_fight_active"}, fight_active, 0);
    chk({tag, "_timer"}, round_timer, TICKS);
    chk({tag, "_round_num"}, round_num, 0);
    chk({tag, "_left_wins"}, left_wins, 0);
    chk({tag, "_right_wins"}, right_wins, 0);
    chk({tag, "_result"}, round_result, 0);
    chk({tag, "_match_over"}, match_over, 0);
    chk({tag, "_winner"}, match_winner, 0);
  endtask
  task automatic wait_fight();
    for (int i = 0; i < 40 && !fight_active; i++)
      step($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), 0);
    if (!fight_active) begin
      $display("FAIL wait_fight: fight_active 0 expected 1");
      $fatal(1, "round never started");
    end
  endtask
  // model: the round outcome is known from the chosen scenario; wins, round number and match winner follow
  task automatic finish_round(input int res);
    if (res == 1 && m_lw < WINS) m_lw++;
    if (res == 2 && m_rw < WINS) m_rw++;
    rq.push_back('{res, m_lw, m_rw, m_num, (ticks >= TICKS) ? 0 : TICKS - ticks});
    if (m_lw == WINS || m_rw == WINS) mq.push_back(m_lw == WINS ? 1 : 2);
    else begin
      m_num = (m_num == 7) ? 7 : m_num + 1;
      sq.push_back(m_num);
    end
  endtask
  task automatic run_round(input int kind);
    int lp = 3, rp = 3, l1, r1, t1, t2;
    wait_fight();
    ticks = 0;
    for (int i = 0; i < GRD; i++) begin
      t1 = (kind == 5) ? 1 : $urandom_range(0, 1);
      ticks += t1;
      step(gnoise(), gnoise(), t1, $urandom_range(0, 1));
    end
    if (kind == 5) begin
      l1 = $urandom_range(1, 3);
      r1 = $urandom_range(1, 3);
      ticks = TICKS;
      finish_round(l1 > r1 ? 1 : r1 > l1 ? 2 : 3);
      for (int i = 0; i < 300 && fight_active; i++) step(l1, r1, 1, $urandom_range(0, 1));
      chk("timeout_end", fight_active, 0);
    end else begin
      for (int i = $urandom_range(0, 6); i > 0; i--) begin
        l1 = safe(lp);
        r1 = safe(rp);
        t1 = ($urandom_range(0, 3) == 0) ? 1 : 0;
        ticks += t1;
        step(l1, r1, t1, $urandom_range(0, 1));
        lp = l1;
        rp = r1;
      end
      t1 = $urandom_range(0, 1);
      t2 = $urandom_range(0, 1);
      case (kind)
        0: begin ticks += t1; finish_round(1); step(safe(lp), 0, t1, 0); end
        1: begin ticks += t1; finish_round(2); step(0, safe(rp), t1, 0); end
        2: begin ticks += t1 + t2; finish_round(1); step(2, 1, t1, 0); step(3, 3, t2, 0); end
        3: begin ticks += t1 + t2; finish_round(2); step(1, 2, t1, 0); step(3, 3, t2, 0); end
        default: begin ticks += t1; finish_round(3); step(0, 0, t1, 0); end
      endcase
      chk("ko_latency", fight_active, 0);
    end
  endtask
  task automatic start_match();
    m_lw = 0;
    m_rw = 0;
    m_num = 1;
    sq.push_back(1);
    step(3, 3, 0, 1);
    chk("start_lw", left_wins, 0);
    chk("start_rw", right_wins, 0);
    chk("start_num", round_num, 1);
    chk("start_active", fight_active, 1);
    chk("start_match_over", match_over, 0);
    chk("start_winner", match_winner, 0);
  endtask
  task automatic run_match(input bit draws);
    start_match();
    for (int n = 0; n < 30 && m_lw < WINS && m_rw < WINS; n++)
      run_round((draws && n < 8) ? 4 : (n >= 12) ? 0 : $urandom_range(0, 5));
    for (int i = 0; i < 20 && !match_over; i++)
      step($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), 0);
    chk("match_over", match_over, 1);
    for (int i = 0; i < 3; i++) step($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), 0);
    chk("over_hold", match_over, 1);
    chk("over_hold_winner", match_winner, m_lw == WINS ? 1 : 2);
    chk("over_hold_lw", left_wins, m_lw);
    chk("over_hold_rw", right_wins, m_rw);
    chk("over_hold_rst_n", player_rst_n, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    step(3, 3, 1, 0);
    step(0, 0, 1, 0);
    chk("idle_tick_ignored", round_timer, TICKS);
    chk("idle_stays", fight_active, 0);
    run_match(1'b0);
    run_match(1'b1);
    for (int m = 0; m < 3; m++) run_match(1'b0);
    start_match();
    run_round(0);
    wait_fight();
    for (int i = 0; i < 59; i++) step(3, 3, 1, 0);
    chk("pre_rst_timer", round_timer, 40);
    chk("pre_rst_lw", left_wins, 1);
    chk("pre_rst_num", round_num, 2);
    rst = 1'b1;
    step(3, 3, 1, 1);
    check_reset("mid_rst");
    step(3, 3, 1, 1);
    chk("rst_start_ignored", fight_active, 0);
    rst = 1'b0;
    step(3, 3, 0, 0);
    chk("post_rst_idle", fight_active, 0);
    chk("post_rst_num", round_num, 0);
    chk("rq_empty", rq.size(), 0);
    chk("sq_empty", sq.size(), 0);
    chk("mq_empty", mq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
